// File: rtl/snoop_pktbuf_pkg.sv
// ============================================================================
// Module : snoop_pktbuf_pkg
// Brief  : Shared bank-state encoding and sizing helpers for snoop_pktbuf.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package snoop_pktbuf_pkg;

    localparam int PKTBUF_DATA_WIDTH_DFLT = 32;
    localparam int PKTBUF_ADDR_WIDTH_DFLT = 10;
    // A packet length needs one bit more than an address so a full bank fits.
    localparam int LEN_EXTRA              = 1;
    localparam int PKTBUF_LEN_WIDTH_DFLT  = PKTBUF_ADDR_WIDTH_DFLT + LEN_EXTRA;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_READY   = 2'd2
    } bank_state_e;

    function automatic int len_width(input int addr_width);
        return addr_width + LEN_EXTRA;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snoop_pktbuf_bank_ram.sv
// ============================================================================
// Module : pktbuf_bank_ram
// Brief  : Simple dual-port RAM, synchronous write, registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pktbuf_bank_ram
    import snoop_pktbuf_pkg::*;
#(
    parameter int DATA_WIDTH = PKTBUF_DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH = PKTBUF_ADDR_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Only the output register is reset; array contents are left as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/snoop_pktbuf.sv
// ============================================================================
// Module : snoop_pktbuf
// Brief  : Double-buffered packet memory between the snooper and the filter.
//          Optional statistics outputs enabled by SNOOP_PKTBUF_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snoop_pktbuf
    import snoop_pktbuf_pkg::*;
#(
    parameter int DATA_WIDTH = PKTBUF_DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH = PKTBUF_ADDR_WIDTH_DFLT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_en,
    input  logic                    done,
    output logic                    mem_ready,
    output logic                    pkt_ready,
    output logic [ADDR_WIDTH:0]     pkt_len,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_done
`ifdef SNOOP_PKTBUF_STATS_EN
    ,
    output logic [31:0]             pkt_count,
    output logic [31:0]             stall_count
`endif
);

    localparam int LEN_W = len_width(ADDR_WIDTH);

    bank_state_e        state_q [2];
    bank_state_e        state_d [2];
    logic [LEN_W-1:0]   len_q   [2];
    logic [LEN_W-1:0]   len_d   [2];
    logic               wbank_q, wbank_d;
    logic               rbank_q, rbank_d;
    logic               rd_sel_q, rd_sel_d;

    logic               w_mem_ready;
    logic               w_pkt_ready;
    logic               w_wr_acc;
    logic               w_release;
    logic [DATA_WIDTH-1:0] w_bank_rd [2];

    assign w_mem_ready = (state_q[wbank_q] != BANK_READY);
    assign w_pkt_ready = (state_q[rbank_q] == BANK_READY);
    assign w_wr_acc    = wr_en && w_mem_ready;
    assign w_release   = rd_done && w_pkt_ready;

    // Write and release never hit the same bank: the write bank is never READY.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wbank_d  = wbank_q;
        rbank_d  = rbank_q;
        rd_sel_d = rd_en ? rbank_q : rd_sel_q;
        if (w_wr_acc) begin
            if (done) begin
                state_d[wbank_q] = BANK_READY;
                len_d[wbank_q]   = LEN_W'(wr_addr) + LEN_W'(1);
                wbank_d          = ~wbank_q;
            end else begin
                state_d[wbank_q] = BANK_FILLING;
            end
        end
        if (w_release) begin
            state_d[rbank_q] = BANK_EMPTY;
            len_d[rbank_q]   = '0;
            rbank_d          = ~rbank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            pktbuf_bank_ram #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_ram (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (w_wr_acc && (wbank_q == 1'(b))),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .rd_en   (rd_en && (rbank_q == 1'(b))),
                .rd_addr (rd_addr),
                .rd_data (w_bank_rd[b])
            );
        end
    endgenerate

    assign mem_ready = w_mem_ready;
    assign pkt_ready = w_pkt_ready;
    assign pkt_len   = w_pkt_ready ? len_q[rbank_q] : '0;
    assign rd_data   = rd_sel_q ? w_bank_rd[1] : w_bank_rd[0];

`ifdef SNOOP_PKTBUF_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        pkt_count_d   = pkt_count_q;
        stall_count_d = stall_count_q;
        if (w_wr_acc && done) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        if (wr_en && !w_mem_ready) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            pkt_count_q   <= pkt_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pkt_count   = pkt_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snoop_pktbuf.sv
// ============================================================================
// Module : tb_snoop_pktbuf
// Brief  : Directed, table-driven bench for snoop_pktbuf (ADDR_WIDTH=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_snoop_pktbuf;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          done = 1'b0;
    logic          mem_ready;
    logic          pkt_ready;
    logic [AW:0]   pkt_len;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_done = 1'b0;
`ifdef SNOOP_PKTBUF_STATS_EN
    logic [31:0]   pkt_count;
    logic [31:0]   stall_count;
`endif

    snoop_pktbuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .done      (done),
        .mem_ready (mem_ready),
        .pkt_ready (pkt_ready),
        .pkt_len   (pkt_len),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_done   (rd_done)
`ifdef SNOOP_PKTBUF_STATS_EN
        ,
        .pkt_count   (pkt_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          we;
        logic          dn;
        logic [AW-1:0] ra;
        logic          re;
        logic          rdn;
        logic          emr;
        logic          epr;
        logic [AW:0]   elen;
        logic          chk;
        logic [DW-1:0] erd;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input int wa, input int wd, input bit we, input bit dn,
                                input int ra, input bit re, input bit rdn,
                                input bit emr, input bit epr, input int elen,
                                input bit chk, input int erd);
        vec_t v;
        v.wa = AW'(wa);  v.wd = DW'(wd);  v.we = we;  v.dn = dn;
        v.ra = AW'(ra);  v.re = re;  v.rdn = rdn;
        v.emr = emr;  v.epr = epr;  v.elen = (AW+1)'(elen);
        v.chk = chk;  v.erd = DW'(erd);
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and leave outputs settled 1 time unit later.
    task automatic cyc(input int wa, input int wd, input bit we, input bit dn,
                       input int ra, input bit re, input bit rdn);
        wr_addr = AW'(wa);  wr_data = DW'(wd);  wr_en = we;  done = dn;
        rd_addr = AW'(ra);  rd_en = re;  rd_done = rdn;
        @(posedge clk);
        #1;
        wr_en = 1'b0;  done = 1'b0;  rd_en = 1'b0;  rd_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal;
    end

    initial begin
        // 10-flit packet into bank 0, read, read+release same cycle
        for (int i = 0; i < 9; i++) add(i, 'hA0 + i, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(9, 'hA9, 1, 1, 0, 0, 0, 1, 1, 10, 0, 0);
        add(0, 0, 0, 0, 3, 1, 0, 1, 1, 10, 1, 'hA3);
        add(0, 0, 0, 0, 9, 1, 1, 1, 0, 0, 1, 'hA9);
        // Fill bank 1 (len 4) then bank 0 (len 7), then blocked writes
        for (int i = 0; i < 3; i++) add(i, 'hB0 + i, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(3, 'hB3, 1, 1, 0, 0, 0, 1, 1, 4, 0, 0);
        for (int i = 0; i < 6; i++) add(i, 'hC0 + i, 1, 0, 0, 0, 0, 1, 1, 4, 0, 0);
        add(6, 'hC6, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0);
        add(0, 'hFF, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        add(1, 'hEE, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 4, 1, 'hB0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 1, 4, 1, 'hB1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 1, 'hB1);
        add(0, 0, 0, 0, 6, 1, 0, 1, 1, 7, 1, 'hC6);
        // Bank 1 completes while bank 0 is released and read
        add(0, 'hD0, 1, 0, 0, 0, 0, 1, 1, 7, 0, 0);
        add(1, 'hD1, 1, 0, 0, 0, 0, 1, 1, 7, 0, 0);
        add(2, 'hD2, 1, 1, 0, 1, 1, 1, 1, 3, 1, 'hC0);
        add(0, 0, 0, 0, 2, 1, 0, 1, 1, 3, 1, 'hD2);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'hD2);
        // Single-flit packet in bank 0, then full 16-flit packet in bank 1
        add(0, 'hE0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 'hE0);
        for (int i = 0; i < 15; i++) add(i, 'h100 + i, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(15, 'h10F, 1, 1, 0, 0, 0, 1, 1, 16, 0, 0);
        add(0, 0, 0, 0, 15, 1, 0, 1, 1, 16, 1, 'h10F);
        add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 'h100);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.mem_ready", 64'(mem_ready), 64'd1);
        check("reset.pkt_ready", 64'(pkt_ready), 64'd0);
        check("reset.pkt_len", 64'(pkt_len), 64'd0);
        check("reset.rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            cyc(vq[i].wa, vq[i].wd, vq[i].we, vq[i].dn, vq[i].ra, vq[i].re, vq[i].rdn);
            check($sformatf("v%0d.mem_ready", i), 64'(mem_ready), 64'(vq[i].emr));
            check($sformatf("v%0d.pkt_ready", i), 64'(pkt_ready), 64'(vq[i].epr));
            check($sformatf("v%0d.pkt_len", i), 64'(pkt_len), 64'(vq[i].elen));
            if (vq[i].chk) check($sformatf("v%0d.rd_data", i), 64'(rd_data), 64'(vq[i].erd));
        end

        // Reset mid-packet: READY bank 0 plus 5 partial flits in bank 1 are discarded
        cyc(0, 'h55, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(i, 'h60 + i, 1, 0, 0, 0, 0);
        check("midrst.pre_pkt_ready", 64'(pkt_ready), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst.mem_ready", 64'(mem_ready), 64'd1);
        check("midrst.pkt_ready", 64'(pkt_ready), 64'd0);
        check("midrst.pkt_len", 64'(pkt_len), 64'd0);
        check("midrst.rd_data", 64'(rd_data), 64'd0);
`ifdef SNOOP_PKTBUF_STATS_EN
        check("midrst.pkt_count", 64'(pkt_count), 64'd0);
        check("midrst.stall_count", 64'(stall_count), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 'h70, 1, 0, 0, 0, 0);
        cyc(1, 'h71, 1, 1, 0, 0, 0);
        check("post.pkt_ready", 64'(pkt_ready), 64'd1);
        check("post.pkt_len", 64'(pkt_len), 64'd2);
        cyc(0, 0, 0, 0, 1, 1, 0);
        check("post.rd_data", 64'(rd_data), 64'h71);

        // Second packet fills bank 1, four blocked writes, release, third packet
        cyc(0, 'h80, 1, 1, 0, 0, 0);
        check("stall.mem_ready", 64'(mem_ready), 64'd0);
        for (int i = 0; i < 4; i++) cyc(i, 'h90 + i, 1, 0, 0, 0, 0);
        check("stall.still_blocked", 64'(mem_ready), 64'd0);
        check("stall.pkt_len", 64'(pkt_len), 64'd2);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("stall.release_mem_ready", 64'(mem_ready), 64'd1);
        check("stall.release_pkt_len", 64'(pkt_len), 64'd1);
        cyc(0, 'hA5, 1, 1, 0, 1, 0);
        check("stall.bank1_rd_data", 64'(rd_data), 64'h80);
        check("stall.final_mem_ready", 64'(mem_ready), 64'd0);
`ifdef SNOOP_PKTBUF_STATS_EN
        check("stats.pkt_count", 64'(pkt_count), 64'd3);
        check("stats.stall_count", 64'(stall_count), 64'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snoop_pktbuf.md
# snoop_pktbuf

Double-buffered packet memory sitting directly downstream of the data/valid snooper. It accepts the snooper's write interface (address, data, write enable, last-flit `done`) and back-pressures it with `mem_ready`. It presents each completed packet, in arrival order, to the packet-filter reader through a registered read port. The reader explicitly releases each bank.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: flit width; must match the snooper.
- `ADDR_WIDTH`, default 10: per-bank address width; each bank holds 2^ADDR_WIDTH flits.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_addr`  in  ADDR_WIDTH  flit index within the current write bank.
- `wr_data`  in  DATA_WIDTH  flit to store.
- `wr_en`  in  1  write strobe; honoured only while `mem_ready`=1.
- `done`  in  1  qualifies `wr_en` as the packet's last flit.
- `mem_ready`  out  1  the current write bank can accept flits.
- `pkt_ready`  out  1  the current read bank holds a complete packet.
- `pkt_len`  out  ADDR_WIDTH+1  flit count of the packet in the read bank.
- `rd_addr`  in  ADDR_WIDTH  flit index within the read bank.
- `rd_en`  in  1  read strobe.
- `rd_data`  out  DATA_WIDTH  registered read data.
- `rd_done`  in  1  reader releases the read bank.

## Operation
- Two banks (0/1). Each has state EMPTY, FILLING or READY (2-bit per bank) and a `len` register.
- Write pointer `wbank` and read pointer `rbank` are 1-bit each and reset to 0. They toggle independently, which preserves FIFO order.
- `mem_ready` = (state[wbank] != READY). It is combinational from registered state.
- Accepted write = `wr_en && mem_ready`. Writes when `mem_ready`=0 are ignored: no RAM write, no state change.
- Accepted write without `done`:
  - RAM[wbank][wr_addr] <= wr_data.
  - EMPTY -> FILLING. FILLING stays FILLING.
- Accepted write with `done`:
  - The RAM write is performed.
  - state[wbank] -> READY.
  - len[wbank] <= wr_addr+1, computed at ADDR_WIDTH+1 bits so that a full bank yields 2^ADDR_WIDTH.
  - `wbank` toggles.
- A single-flit packet (`done` on the first write) goes EMPTY -> READY directly.
- `pkt_ready` = (state[rbank] == READY). `pkt_len` = len[rbank] when `pkt_ready`=1, otherwise 0.
- `rd_en`: rd_data <= RAM[rbank][rd_addr] on the next edge. It is legal regardless of `pkt_ready`; the data is undefined if the bank is not READY. `rd_data` holds its value when `rd_en`=0.
- `rd_done`:
  - When `pkt_ready`=1: state[rbank] -> EMPTY, len -> 0, `rbank` toggles.
  - When `pkt_ready`=0: ignored.
- Simultaneous completion on one bank and release of the other bank in the same cycle: both take effect.
- A bank cannot be both written and released in one cycle, because the write bank is never READY.
- `rd_en` and `rd_done` in the same cycle: the read uses the pre-toggle `rbank`.

## Timing
- Reset values:
  - `mem_ready`=1, `pkt_ready`=0, `pkt_len`=0, `rd_data`=0.
  - Both banks EMPTY, `wbank`=`rbank`=0.
  - RAM contents are not reset.
- Reset mid-packet discards all buffered and partial packets. The snooper must be reset together with this block.
- Write latency: the flit is stored on the edge where it is accepted.
- `done` accepted at edge N:
  - `pkt_ready`=1 (if that bank is the read bank) and `pkt_len` valid after edge N.
  - `mem_ready` after edge N reflects the other bank. It stays 1 if that bank is EMPTY and drops to 0 if it is READY.
- Read latency: exactly 1 cycle from `rd_en` to `rd_data`. Back-to-back reads are allowed every cycle.
- `rd_done` at edge M: the bank is writable at edge M+1. `mem_ready` rises combinationally after edge M.
- Throughput: with prompt releases, the snooper never stalls.

## Configuration
- `SNOOP_PKTBUF_STATS_EN` defined: adds two outputs.
  - `pkt_count` (32 bit): increments on every accepted `done`.
  - `stall_count` (32 bit): increments on every cycle with `wr_en`=1 and `mem_ready`=0.
  - Both reset to 0 and wrap at 2^32.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

## Structure
- Shared package `snoop_pktbuf_pkg`: bank-state encoding (EMPTY=0, FILLING=1, READY=2) and the length-width localparam (ADDR_WIDTH+1).
- Sub-module `pktbuf_bank_ram`:
  - Simple dual-port RAM of 2^ADDR_WIDTH x DATA_WIDTH.
  - One synchronous write port and one registered read port.
  - Instantiated twice.
- The top level muxes `rd_data` by a registered copy of `rbank`.

## Test plan
- After reset -> `mem_ready`=1, `pkt_ready`=0, `pkt_len`=0, `rd_data`=0.
- Write 10 flits 0xA0..0xA9 at addresses 0..9 with `done` on the last -> next cycle `pkt_ready`=1, `pkt_len`=10; `rd_en` at addr 3 -> `rd_data`=0xA3 one cycle later.
- Fill both banks (lengths 4 and 7) without releasing -> `mem_ready`=0; further `wr_en` writes nothing (contents are unchanged on readback). `rd_done` -> `mem_ready`=1 next cycle, `pkt_len`=7.
- In one cycle, `done` completes bank 1 while `rd_done` releases bank 0 -> bank 1 READY, `rbank`=1, `pkt_len`=bank-1 length, `mem_ready`=1.
- Single-flit packet (`done` at addr 0) -> `pkt_len`=1. Full packet ending at addr 2^ADDR_WIDTH-1 -> `pkt_len`=2^ADDR_WIDTH.
- Assert `rst` mid-packet after 5 flits -> all outputs return to reset values; the next packet starts in bank 0. With `SNOOP_PKTBUF_STATS_EN`: 3 packets plus 4 blocked writes -> `pkt_count`=3, `stall_count`=4.
